// File: rtl/fu_pkg.sv
// rtl/fu_pkg.sv - shared constants for the functional-unit dispatcher
package fu_pkg;

  localparam int FU_N   = 32;
  localparam int FU_L   = 4;
  localparam int FU_NU  = 3;
  localparam int FU_D   = 8;
  localparam int FU_OPW = 6;

  // Unit slot assignment on the dispatcher's unit ports
  localparam int FU_BASIC = 0;
  localparam int FU_MULT  = 1;
  localparam int FU_DIV   = 2;

  // Opcode encodings understood by FpuBasic / FpuMultDiv / AluDiv
  typedef enum logic [FU_OPW-1:0] {
    OP_FADD  = 6'h01,
    OP_FSUB  = 6'h02,
    OP_FMUL  = 6'h03,
    OP_FDIV  = 6'h04,
    OP_FSQRT = 6'h05,
    OP_IDIV  = 6'h10,
    OP_IREM  = 6'h11
  } fu_op_e;

  function automatic int fu_unit_width(input int nu);
    return (nu > 1) ? $clog2(nu) : 1;
  endfunction

endpackage

// File: rtl/fu_dispatch_if.sv
// rtl/fu_dispatch_if.sv - core request/response and unit-side handshake bundle
import fu_pkg::*;

interface fu_dispatch_if #(
  parameter int N   = FU_N,
  parameter int L   = FU_L,
  parameter int NU  = FU_NU,
  parameter int OPW = FU_OPW
);
  localparam int DW = N * L;
  localparam int UW = fu_unit_width(NU);

  logic              req_valid;
  logic              req_ready;
  logic [UW-1:0]     req_unit;
  logic [OPW-1:0]    req_op;
  logic [DW-1:0]     req_a;
  logic [DW-1:0]     req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic [UW-1:0]     rsp_unit;
  logic [NU-1:0]     fu_valid;
  logic [NU-1:0]     fu_stall;
  logic [NU*OPW-1:0] fu_op;
  logic [NU*DW-1:0]  fu_a;
  logic [NU*DW-1:0]  fu_b;
  logic [NU*DW-1:0]  fu_res;
  logic [NU-1:0]     fu_finish;

  modport master (
    output req_valid, req_unit, req_op, req_a, req_b, rsp_ready, fu_res, fu_finish,
    input  req_ready, rsp_valid, rsp_data, rsp_unit, fu_valid, fu_stall, fu_op, fu_a, fu_b
  );

  modport slave (
    input  req_valid, req_unit, req_op, req_a, req_b, rsp_ready, fu_res, fu_finish,
    output req_ready, rsp_valid, rsp_data, rsp_unit, fu_valid, fu_stall, fu_op, fu_a, fu_b
  );

endinterface

// File: rtl/fu_order_fifo.sv
// rtl/fu_order_fifo.sv - issue-order tag FIFO with same-cycle push/pop
module fu_order_fifo #(
  parameter int W = 2,
  parameter int D = 8
) (
  input  logic         phi,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == (AW+1)'(D));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd];

  // D is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge phi or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < D; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fu_dispatch.sv
// rtl/fu_dispatch.sv - in-order front-end for long-latency functional units
// Optional same-cycle result bypass enabled by defining FU_BYPASS_EN.
import fu_pkg::*;

module fu_dispatch #(
  parameter int N   = FU_N,
  parameter int L   = FU_L,
  parameter int NU  = FU_NU,
  parameter int D   = FU_D,
  parameter int OPW = FU_OPW
) (
  input  logic         phi,
  input  logic         rst_n,
  fu_dispatch_if.slave bus
);
  localparam int DW = N * L;
  localparam int UW = fu_unit_width(NU);

  logic [NU-1:0] r_hold_v;
  logic [DW-1:0] r_hold_d [NU];

  logic [UW-1:0] w_head;
  logic          w_q_full;
  logic          w_q_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_unit_ok;
  logic          w_req_stall;
  logic [NU-1:0] w_stall;
  logic          w_head_hv;
  logic [DW-1:0] w_head_d;
  logic          w_byp;
  logic          w_byp_pop;

  fu_order_fifo #(
    .W (UW),
    .D (D)
  ) u_order (
    .phi     (phi),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (bus.req_unit),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_q_full),
    .o_empty (w_q_empty)
  );

  assign w_unit_ok     = (32'(bus.req_unit) < 32'(NU));
  assign bus.req_ready = ~w_q_full & ~w_req_stall & w_unit_ok;
  assign w_push        = bus.req_valid & bus.req_ready;

  assign bus.fu_op = {NU{bus.req_op}};
  assign bus.fu_a  = {NU{bus.req_a}};
  assign bus.fu_b  = {NU{bus.req_b}};

  always_comb begin
    bus.fu_valid = '0;
    for (int u = 0; u < NU; u++) begin
      bus.fu_valid[u] = w_push & (bus.req_unit == UW'(u));
    end
  end

  // A draining unit is released in the pop cycle so it can refill the hold
  always_comb begin
    w_stall = '0;
    for (int u = 0; u < NU; u++) begin
      w_stall[u] = r_hold_v[u] & ~(w_pop & (w_head == UW'(u)));
    end
  end

  assign bus.fu_stall = w_stall;

  always_comb begin
    w_req_stall = 1'b0;
    w_head_hv   = 1'b0;
    w_head_d    = '0;
    for (int u = 0; u < NU; u++) begin
      if (bus.req_unit == UW'(u)) begin
        w_req_stall = w_stall[u];
      end
      if (w_head == UW'(u)) begin
        w_head_hv = r_hold_v[u];
        w_head_d  = r_hold_d[u];
      end
    end
  end

`ifdef FU_BYPASS_EN
  logic          w_head_fin;
  logic [DW-1:0] w_head_res;

  always_comb begin
    w_head_fin = 1'b0;
    w_head_res = '0;
    for (int u = 0; u < NU; u++) begin
      if (w_head == UW'(u)) begin
        w_head_fin = bus.fu_finish[u];
        w_head_res = bus.fu_res[u*DW +: DW];
      end
    end
  end

  assign w_byp        = ~w_q_empty & ~w_head_hv & w_head_fin;
  assign bus.rsp_data = w_byp ? w_head_res : w_head_d;
`else
  assign w_byp        = 1'b0;
  assign bus.rsp_data = w_head_d;
`endif

  assign bus.rsp_valid = (~w_q_empty & w_head_hv) | w_byp;
  assign bus.rsp_unit  = w_head;
  assign w_pop         = bus.rsp_valid & bus.rsp_ready;
  assign w_byp_pop     = w_byp & w_pop;

  // Capture wins over clear so a same-cycle finish refills a draining hold
  always_ff @(posedge phi or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_v <= '0;
      for (int u = 0; u < NU; u++) begin
        r_hold_d[u] <= '0;
      end
    end else begin
      for (int u = 0; u < NU; u++) begin
        if (bus.fu_finish[u] && !w_stall[u] && !(w_byp_pop && (w_head == UW'(u)))) begin
          r_hold_v[u] <= 1'b1;
          r_hold_d[u] <= bus.fu_res[u*DW +: DW];
        end else if (w_pop && (w_head == UW'(u))) begin
          r_hold_v[u] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fu_dispatch.sv
// tb/tb_fu_dispatch.sv - self-checking bench for fu_dispatch
import fu_pkg::*;

module tb_fu_dispatch;
  localparam int N   = FU_N;
  localparam int L   = FU_L;
  localparam int NU  = FU_NU;
  localparam int D   = FU_D;
  localparam int OPW = FU_OPW;
  localparam int DW  = N * L;
  localparam int UW  = fu_unit_width(NU);
`ifdef FU_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic phi   = 1'b0;
  logic rst_n = 1'b1;
  always #5 phi = ~phi;

  fu_dispatch_if #(.N(N), .L(L), .NU(NU), .OPW(OPW)) bus ();

  fu_dispatch #(.N(N), .L(L), .NU(NU), .D(D), .OPW(OPW)) dut (
    .phi   (phi),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {int unit; logic [DW-1:0] res; int rdy;} pend_t;
  typedef struct {int unit; logic [DW-1:0] res; int icyc;} exp_t;
  typedef struct {int unit; logic [OPW-1:0] op; logic [DW-1:0] a; logic [DW-1:0] b; int lat; bit acc;} vec_t;

  pend_t pend_q[$];
  exp_t  sb_q[$];
  vec_t  tbl[9];

  int n_vec = 0;
  int n_err = 0;
  int cycle = 0;
  int cur_lat = 1;
  int pop_cyc = 0;
  int last_issue_cyc = 0;

  logic          s_acc, s_pop, s_ready, s_rsp_valid;
  logic [NU-1:0] s_stall, s_fin_take, s_fu_valid;
  int            s_unit;
  logic [DW-1:0] s_res;

  function automatic logic [DW-1:0] model_res(int u, logic [OPW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    return (a ^ {L{N'(op)}}) + b + DW'(u);
  endfunction

  function automatic bit has_pend(int u);
    foreach (pend_q[i]) if (pend_q[i].unit == u) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_units();
    logic [NU-1:0]    fin;
    logic [NU*DW-1:0] res;
    fin = '0;
    res = '0;
    for (int u = 0; u < NU; u++) begin
      for (int i = 0; i < pend_q.size(); i++) begin
        if (pend_q[i].unit == u) begin
          if (cycle >= pend_q[i].rdy) begin
            fin[u] = 1'b1;
            res[u*DW +: DW] = pend_q[i].res;
          end
          break;
        end
      end
    end
    bus.fu_finish = fin;
    bus.fu_res    = res;
  endtask

  task automatic step();
    logic [NU-1:0] exp_v;
    bit ok;
    exp_t e;
    @(negedge phi);
    s_ready     = bus.req_ready;
    s_rsp_valid = bus.rsp_valid;
    s_stall     = bus.fu_stall;
    s_fu_valid  = bus.fu_valid;
    s_acc       = bus.req_valid & bus.req_ready;
    s_pop       = bus.rsp_valid & bus.rsp_ready;
    s_fin_take  = bus.fu_finish & ~bus.fu_stall;
    s_unit      = int'(bus.req_unit);
    s_res       = model_res(s_unit, bus.req_op, bus.req_a, bus.req_b);
    exp_v = '0;
    for (int u = 0; u < NU; u++) exp_v[u] = s_acc && (bus.req_unit == UW'(u));
    chk("fu_valid", s_fu_valid, exp_v);
    if (bus.req_valid) begin
      ok = 1'b1;
      for (int u = 0; u < NU; u++) begin
        if (bus.fu_a[u*DW +: DW] !== bus.req_a || bus.fu_b[u*DW +: DW] !== bus.req_b ||
            bus.fu_op[u*OPW +: OPW] !== bus.req_op) ok = 1'b0;
      end
      chk("fu_broadcast", ok, 1);
    end
    if (s_pop) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_unit", bus.rsp_unit, e.unit);
        chk("rsp_data", bus.rsp_data, e.res);
        pop_cyc = cycle;
      end
    end
    for (int u = 0; u < NU; u++) begin
      if (bus.fu_finish[u]) assert (has_pend(u)) else $error("FAIL protocol: finish on unit %0d with no queued tag", u);
    end
    @(posedge phi);
    #1;
    cycle++;
    if (rst_n) begin
      for (int u = 0; u < NU; u++) begin
        if (s_fin_take[u]) begin
          for (int i = 0; i < pend_q.size(); i++) begin
            if (pend_q[i].unit == u) begin
              pend_q.delete(i);
              break;
            end
          end
        end
      end
      if (s_acc) begin
        pend_q.push_back('{s_unit, s_res, cycle + cur_lat});
        sb_q.push_back('{s_unit, s_res, cycle});
        last_issue_cyc = cycle;
      end
    end
    drive_units();
  endtask

  task automatic issue(int u, logic [OPW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b, int lat);
    bit done;
    done = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_unit  = UW'(u);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    cur_lat       = lat;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      if (s_acc) done = 1'b1;
    end
    if (!done) chk("issue_timeout", 0, 1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 400 && (sb_q.size() != 0 || pend_q.size() != 0); i++) step();
    chk("drain_left", sb_q.size(), 0);
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int ic;
    bus.req_valid = 1'b0;
    bus.req_unit  = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    bus.fu_finish = '0;
    bus.fu_res    = '0;

    #1 rst_n = 1'b0;
    #2;
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_fu_valid", bus.fu_valid, 0);
    chk("reset_fu_stall", bus.fu_stall, 0);
    chk("reset_rsp_data", bus.rsp_data, 0);
    chk("reset_rsp_unit", bus.rsp_unit, 0);
    chk("reset_req_ready", bus.req_ready, 1);
    step();
    step();
    rst_n = 1'b1;
    step();

    tbl[0] = '{FU_BASIC, OP_FADD, {L{32'h3F800000}}, {L{32'h40000000}}, 2, 1'b1};
    tbl[1] = '{FU_MULT,  OP_FMUL, {L{32'h40400000}}, {L{32'h3F000000}}, 4, 1'b1};
    tbl[2] = '{FU_DIV,   OP_IDIV, {L{32'h00000064}}, {L{32'h00000007}}, 1, 1'b1};
    tbl[3] = '{3,        OP_FADD, {L{32'hDEADBEEF}}, {L{32'h12345678}}, 1, 1'b0};
    tbl[4] = '{FU_MULT,  OP_FDIV, {L{32'hFFFFFFFF}}, {L{32'h00000001}}, 1, 1'b1};
    tbl[5] = '{FU_BASIC, OP_FSUB, {L{32'h80000000}}, {L{32'h7FFFFFFF}}, 3, 1'b1};
    tbl[6] = '{FU_DIV,   OP_IREM, {L{32'h0000FFFF}}, {L{32'h00000010}}, 6, 1'b1};
    tbl[7] = '{3,        OP_FMUL, {L{32'h00000000}}, {L{32'h00000000}}, 1, 1'b0};
    tbl[8] = '{FU_BASIC, OP_FSQRT, {L{32'h41800000}}, {L{32'h00000000}}, 1, 1'b1};

    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].acc) begin
        issue(tbl[i].unit, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lat);
      end else begin
        bus.req_valid = 1'b1;
        bus.req_unit  = UW'(tbl[i].unit);
        bus.req_op    = tbl[i].op;
        bus.req_a     = tbl[i].a;
        bus.req_b     = tbl[i].b;
        step();
        chk("oob_req_ready", s_ready, 0);
        chk("oob_fu_valid", s_fu_valid, 0);
        bus.req_valid = 1'b0;
      end
    end
    drain();

    issue(FU_MULT, OP_FMUL, {L{32'h3F800000}}, {L{32'h3F800000}}, 5);
    ic = last_issue_cyc;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (s_pop) found = 1'b1;
    end
    chk("single_seen", found, 1);
    chk("single_latency", pop_cyc - ic, 6 - BYP);
    step();
    chk("single_idle_rsp_valid", s_rsp_valid, 0);
    chk("single_queue_empty", sb_q.size(), 0);

    issue(FU_DIV, OP_IDIV, rnd(), rnd(), 20);
    issue(FU_BASIC, OP_FADD, rnd(), rnd(), 3);
    repeat (8) step();
    chk("ooo_stall0_held", s_stall[0], 1);
    chk("ooo_rsp_blocked", s_rsp_valid, 0);
    drain();
    step();
    chk("ooo_stall0_clear", s_stall[0], 0);

    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ic = last_issue_cyc;
      issue(FU_BASIC, OP_FADD, rnd(), rnd(), 1);
      if (k > 0) chk("b2b_one_per_cycle", last_issue_cyc - ic, 1);
      chk("b2b_no_stall", s_stall[0], 0);
    end
    drain();

    bus.rsp_ready = 1'b0;
    issue(FU_BASIC, OP_FSUB, rnd(), rnd(), 1);
    step();
    step();
    chk("b2b_stall_before_capture", s_stall[0], 0);
    bus.req_valid = 1'b1;
    bus.req_unit  = UW'(FU_BASIC);
    step();
    chk("b2b_stall_after_capture", s_stall[0], 1);
    chk("b2b_stalled_req_ready", s_ready, 0);
    bus.req_valid = 1'b0;
    drain();

    for (int p = 0; p < 3; p++) begin
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < D; i++) issue(i % NU, OP_FMUL, rnd(), rnd(), 12);
      bus.req_valid = 1'b1;
      bus.req_unit  = UW'(FU_BASIC);
      bus.req_op    = OP_FADD;
      bus.req_a     = rnd();
      bus.req_b     = rnd();
      cur_lat       = 12;
      step();
      chk("full_req_ready", s_ready, 0);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
        step();
        if (s_rsp_valid) found = 1'b1;
      end
      chk("full_head_ready", found, 1);
      bus.rsp_ready = 1'b1;
      step();
      chk("full_pop", s_pop, 1);
      chk("full_no_bypass_push", s_ready, 0);
      bus.rsp_ready = 1'b0;
      step();
      chk("full_refill_accept", s_acc, 1);
      bus.req_valid = 1'b0;
      drain();
    end

    bus.rsp_ready = 1'b0;
    issue(FU_DIV, OP_IDIV, rnd(), rnd(), 40);
    issue(FU_BASIC, OP_FADD, rnd(), rnd(), 1);
    issue(FU_MULT, OP_FMUL, rnd(), rnd(), 1);
    issue(FU_DIV, OP_IREM, rnd(), rnd(), 40);
    repeat (4) step();
    chk("pre_reset_stall", s_stall, NU'(3));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", bus.rsp_valid, 0);
    chk("async_fu_stall", bus.fu_stall, 0);
    chk("async_req_ready", bus.req_ready, 1);
    pend_q.delete();
    sb_q.delete();
    drive_units();
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_rsp_valid", s_rsp_valid, 0);
    bus.rsp_ready = 1'b1;
    issue(FU_DIV, OP_IDIV, rnd(), rnd(), 2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
